// File: rtl/crc3_rx_check.sv
// Serial CRC-3 frame checker for the generator's MSB-first codeword.
// Recovers the message, flags CRC status, drops stalled frames.
module crc3_rx_check #(
    parameter int         MSG_W   = 5,
    parameter logic [2:0] POLY    = 3'b011,
    parameter int         GAP_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             frame_valid,
    output logic [MSG_W-1:0] msg,
    output logic [2:0]       crc_rx,
    output logic             crc_ok,
    output logic             abort,
    output logic [7:0]       err_count
);

    localparam int FRAME_W = MSG_W + 3;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_MAX - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   bit_cnt;
    logic [2:0]         r;
    logic [2:0]         r_nx;
    logic [FRAME_W-1:0] sr;
    logic [FRAME_W-1:0] sr_nx;
    logic [7:0]         gap_cnt;
    logic               fb;
    logic               last_bit;
    logic               gap_hit;

    assign busy = (bit_cnt != '0);

    // Next CRC/shift values and frame-level events for the current bit.
    always_comb begin
        fb       = r[2] ^ bit_in;
        r_nx     = {r[1], r[0] ^ (fb & POLY[1]), fb & POLY[0]};
        sr_nx    = {sr[FRAME_W-2:0], bit_in};
        last_bit = bit_valid && (bit_cnt == LAST_CNT);
        gap_hit  = (state == RECV) && !bit_valid
                   && (gap_cnt == GAP_LAST);
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: a bit starts a frame; last bit or gap timeout ends it.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bit_valid) state_nx = RECV;
            RECV: begin
                if (last_bit)     state_nx = IDLE;
                else if (gap_hit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: bit capture, CRC, completion outputs, gap timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            r           <= '0;
            sr          <= '0;
            gap_cnt     <= '0;
            frame_valid <= 1'b0;
            abort       <= 1'b0;
            msg         <= '0;
            crc_rx      <= '0;
            crc_ok      <= 1'b0;
            err_count   <= '0;
        end else begin
            frame_valid <= 1'b0;
            abort       <= 1'b0;
            if (bit_valid) begin
                gap_cnt <= '0;
                if (last_bit) begin
                    bit_cnt     <= '0;
                    r           <= '0;
                    sr          <= '0;
                    msg         <= sr_nx[FRAME_W-1:3];
                    crc_rx      <= sr_nx[2:0];
                    crc_ok      <= (r_nx == 3'b000);
                    frame_valid <= 1'b1;
                    if (r_nx != 3'b000 && err_count != 8'hff)
                        err_count <= err_count + 8'd1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    r       <= r_nx;
                    sr      <= sr_nx;
                end
            end else if (gap_hit) begin
                abort   <= 1'b1;
                bit_cnt <= '0;
                r       <= '0;
                sr      <= '0;
                gap_cnt <= '0;
            end else if (state == RECV) begin
                gap_cnt <= gap_cnt + 8'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule
